// File: rtl/fp64_pkg.sv
// Shared FP64 field widths, FSM encodings and classification helper.
// Pure declarations: no latency, no flow control.
package fp64_pkg;

    localparam int FP64_BIAS = 1023;
    localparam int EXP_W     = 11;
    localparam int FRAC_W    = 52;
    localparam int SIG_W     = 53;
    localparam int UEXP_W    = 12;

    // Subnormals use the minimum normal exponent before normalisation.
    localparam logic [UEXP_W-1:0] EXP_SUB  = UEXP_W'(1 - FP64_BIAS);
    localparam logic [UEXP_W-1:0] EXP_BIAS = UEXP_W'(FP64_BIAS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_NORM,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic zero;
        logic sub;
        logic inf;
        logic nan;
        logic snan;
    } fp_class_t;

    function automatic fp_class_t fp_classify(input logic [EXP_W-1:0]  e,
                                              input logic [FRAC_W-1:0] f);
        fp_class_t c;
        logic      e_zero;
        logic      e_max;
        logic      f_zero;
        e_zero = (e == '0);
        e_max  = (e == '1);
        f_zero = (f == '0);
        c.zero = e_zero & f_zero;
        c.sub  = e_zero & ~f_zero;
        c.inf  = e_max & f_zero;
        c.nan  = e_max & ~f_zero;
        c.snan = e_max & ~f_zero & ~f[FRAC_W-1];
        return c;
    endfunction

endpackage

// File: rtl/fp64_lzc53.sv
// Combinational 53-bit leading-zero count; all-zero input returns 53.
// Zero latency, no flow control.
module fp64_lzc53 (
    input  logic [52:0] din,
    output logic [5:0]  cnt
);

    // Scanning upward lets the highest set bit overwrite lower ones.
    always_comb begin
        cnt = 6'd53;
        for (int i = 0; i < 53; i++) begin
            if (din[i]) cnt = 6'(52 - i);
        end
    end

endmodule

// File: rtl/fp64_unpack_stage.sv
// Classifies a packed double into sign, unbiased exponent and explicit-hidden-bit significand.
// Ready two edges after accept, plus ceil(lzc/SHIFT_PER_CYCLE) for subnormals; en=0 freezes everything.
module fp64_unpack_stage
    import fp64_pkg::*;
#(
    parameter int SHIFT_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [63:0] A,
    output logic        busy,
    output logic        ready,
    output logic        sign,
    output logic [11:0] exp,
    output logic [52:0] mant,
    output logic        is_zero,
    output logic        is_sub,
    output logic        is_inf,
    output logic        is_nan,
    output logic        is_snan
);

    localparam logic [5:0] SHIFT_MAX = 6'(SHIFT_PER_CYCLE);

    state_t            state;
    state_t            state_nxt;
    logic [63:0]       a_q;
    fp_class_t         cls;
    fp_class_t         cls_q;
    logic [5:0]        lz;
    logic [5:0]        shamt;
    logic [SIG_W-1:0]  mant_sh;

    assign cls = fp_classify(a_q[62:52], a_q[FRAC_W-1:0]);

    fp64_lzc53 u_lzc (
        .din (mant),
        .cnt (lz)
    );

    // Clamping to lz guarantees the shift never pushes past bit 52.
    assign shamt   = (lz < SHIFT_MAX) ? lz : SHIFT_MAX;
    assign mant_sh = mant << shamt;

    assign {is_zero, is_sub, is_inf, is_nan, is_snan} = cls_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else if (en) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        ready     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (load) state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                busy      = 1'b1;
                state_nxt = cls.sub ? ST_NORM : ST_DONE;
            end
            ST_NORM: begin
                busy = 1'b1;
                if (mant_sh[SIG_W-1]) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                ready = 1'b1;
                if (load) state_nxt = ST_DECODE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_q   <= '0;
            sign  <= 1'b0;
            exp   <= '0;
            mant  <= '0;
            cls_q <= '0;
        end else if (en) begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (load) a_q <= A;
                end
                ST_DECODE: begin
                    sign  <= a_q[63];
                    cls_q <= cls;
                    if (cls.zero) begin
                        exp  <= '0;
                        mant <= '0;
                    end else if (cls.sub) begin
                        exp  <= EXP_SUB;
                        mant <= {1'b0, a_q[FRAC_W-1:0]};
                    end else begin
                        // Inf/NaN fall through here too: E=2047 yields exp=1024.
                        exp  <= {1'b0, a_q[62:52]} - EXP_BIAS;
                        mant <= {1'b1, a_q[FRAC_W-1:0]};
                    end
                end
                ST_NORM: begin
                    mant <= mant_sh;
                    exp  <= exp - {6'd0, shamt};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp64_unpack_stage.sv
// Directed bench for fp64_unpack_stage with SHIFT_PER_CYCLE=1 and =4 instances side by side.
module tb_fp64_unpack_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b1;
    logic        load = 1'b0;
    logic [63:0] A = '0;

    logic        busy1, ready1, sign1, z1, s1, i1, n1, sn1;
    logic [11:0] exp1;
    logic [52:0] mant1;
    logic        busy4, ready4, sign4, z4, s4, i4, n4, sn4;
    logic [11:0] exp4;
    logic [52:0] mant4;
    logic [4:0]  fl1, fl4;

    assign fl1 = {z1, s1, i1, n1, sn1};
    assign fl4 = {z4, s4, i4, n4, sn4};

    int checks = 0;
    int failures = 0;

    localparam logic [63:0] JUNK = 64'hA5A5_5A5A_F00D_CAFE;
    localparam logic [52:0] ONE52 = 53'h10000000000000;

    always #5 clk = ~clk;

    fp64_unpack_stage #(.SHIFT_PER_CYCLE(1)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .A(A),
        .busy(busy1), .ready(ready1), .sign(sign1), .exp(exp1), .mant(mant1),
        .is_zero(z1), .is_sub(s1), .is_inf(i1), .is_nan(n1), .is_snan(sn1)
    );

    fp64_unpack_stage #(.SHIFT_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .load(load), .A(A),
        .busy(busy4), .ready(ready4), .sign(sign4), .exp(exp4), .mant(mant4),
        .is_zero(z4), .is_sub(s4), .is_inf(i4), .is_nan(n4), .is_snan(sn4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Loads one operand and counts edges until each instance raises ready (-1 on timeout).
    task automatic run_op(input logic [63:0] a, output int lat1, output int lat4, output int bcnt);
        A    = a;
        load = 1'b1;
        lat1 = -1;
        lat4 = -1;
        bcnt = 0;
        for (int e = 1; e <= 200; e++) begin
            step();
            if (e == 1) begin
                load = 1'b0;
                A    = JUNK;
            end
            if (busy1) bcnt++;
            if (ready1 && lat1 < 0) lat1 = e;
            if (ready4 && lat4 < 0) lat4 = e;
            if (lat1 >= 0 && lat4 >= 0) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        en  = 1'b1;
        step();
        step();
        checks++;
        if ({busy1, ready1, sign1, exp1, mant1, fl1} !== '0) begin
            failures++;
            $display("FAIL reset_s1 got busy=%b ready=%b sign=%b exp=%h mant=%h flags=%b want all 0",
                     busy1, ready1, sign1, exp1, mant1, fl1);
        end
        checks++;
        if ({busy4, ready4, sign4, exp4, mant4, fl4} !== '0) begin
            failures++;
            $display("FAIL reset_s4 got busy=%b ready=%b exp=%h mant=%h want all 0", busy4, ready4, exp4, mant4);
        end
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({busy1, ready1} !== 2'b00) begin
            failures++;
            $display("FAIL idle_no_load got busy=%b ready=%b want 0 0", busy1, ready1);
        end
    endtask

    task automatic test_normal();
        logic [63:0] va [2] = '{64'h3FF0000000000000, 64'hC004000000000000};
        logic        vs [2] = '{1'b0, 1'b1};
        logic [11:0] ve [2] = '{12'h000, 12'h001};
        logic [52:0] vm [2] = '{53'h10000000000000, 53'h14000000000000};
        int l1, l4, bc;
        for (int i = 0; i < 2; i++) begin
            run_op(va[i], l1, l4, bc);
            checks++;
            if (l1 != 2 || l4 != 2) begin
                failures++;
                $display("FAIL normal_lat[%0d] got s1=%0d s4=%0d want 2", i, l1, l4);
            end
            checks++;
            if ({sign1, exp1, mant1, fl1} !== {vs[i], ve[i], vm[i], 5'b00000}) begin
                failures++;
                $display("FAIL normal_res[%0d] got sign=%b exp=%h mant=%h flags=%b want %b %h %h 00000",
                         i, sign1, exp1, mant1, fl1, vs[i], ve[i], vm[i]);
            end
        end
        for (int k = 0; k < 3; k++) step();
        checks++;
        if ({ready1, busy1, exp1, mant1} !== {1'b1, 1'b0, 12'h001, 53'h14000000000000}) begin
            failures++;
            $display("FAIL done_hold got ready=%b busy=%b exp=%h mant=%h", ready1, busy1, exp1, mant1);
        end
    endtask

    task automatic test_special();
        logic [63:0] va [4] = '{64'h7FF0000000000000, 64'h7FF8000000000000,
                                64'h7FF0000000000001, 64'h8000000000000000};
        logic        vs [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [11:0] ve [4] = '{12'h400, 12'h400, 12'h400, 12'h000};
        logic [52:0] vm [4] = '{53'h10000000000000, 53'h18000000000000, 53'h10000000000001, 53'h0};
        logic [4:0]  vf [4] = '{5'b00100, 5'b00010, 5'b00011, 5'b10000};
        int l1, l4, bc;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], l1, l4, bc);
            checks++;
            if (l1 != 2) begin
                failures++;
                $display("FAIL special_lat[%0d] got %0d want 2", i, l1);
            end
            checks++;
            if ({sign1, exp1, mant1, fl1} !== {vs[i], ve[i], vm[i], vf[i]}) begin
                failures++;
                $display("FAIL special_res[%0d] got sign=%b exp=%h mant=%h flags=%b want %b %h %h %b",
                         i, sign1, exp1, mant1, fl1, vs[i], ve[i], vm[i], vf[i]);
            end
        end
    endtask

    task automatic test_subnormal();
        logic [63:0] va  [3] = '{64'h0000000000000001, 64'h0008000000000000, 64'h000000000000000F};
        logic [11:0] ve  [3] = '{12'hBCE, 12'hC01, 12'hBD1};
        logic [52:0] vm  [3] = '{53'h10000000000000, 53'h10000000000000, 53'h1E000000000000};
        int          vl1 [3] = '{54, 3, 51};
        int          vl4 [3] = '{15, 3, 15};
        int l1, l4, bc;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], l1, l4, bc);
            checks++;
            if (l1 != vl1[i] || l4 != vl4[i]) begin
                failures++;
                $display("FAIL sub_lat[%0d] got s1=%0d s4=%0d want %0d %0d", i, l1, l4, vl1[i], vl4[i]);
            end
            checks++;
            if (bc != vl1[i] - 1) begin
                failures++;
                $display("FAIL sub_busy[%0d] got %0d cycles want %0d", i, bc, vl1[i] - 1);
            end
            checks++;
            if ({sign1, exp1, mant1, fl1} !== {1'b0, ve[i], vm[i], 5'b01000}) begin
                failures++;
                $display("FAIL sub_res_s1[%0d] got exp=%h mant=%h flags=%b want %h %h 01000",
                         i, exp1, mant1, fl1, ve[i], vm[i]);
            end
            checks++;
            if ({exp4, mant4, fl4} !== {ve[i], vm[i], 5'b01000}) begin
                failures++;
                $display("FAIL sub_res_s4[%0d] got exp=%h mant=%h flags=%b want %h %h 01000",
                         i, exp4, mant4, fl4, ve[i], vm[i]);
            end
        end
    endtask

    // Stall 5 cycles mid-NORM, then pulse load while still busy.
    task automatic test_stall();
        int l1 = -1;
        int l4 = -1;
        A    = 64'h1;
        load = 1'b1;
        step();
        load = 1'b0;
        A    = JUNK;
        for (int e = 2; e <= 11; e++) step();
        // Nine shifts done on S=1, thirty-six on S=4.
        checks++;
        if ({exp1, mant1, exp4, mant4} !== {12'hBF9, 53'd1 << 9, 12'hBDE, 53'd1 << 36}) begin
            failures++;
            $display("FAIL norm_progress got s1 %h/%h s4 %h/%h", exp1, mant1, exp4, mant4);
        end
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if ({busy1, exp1, mant1, busy4, exp4, mant4} !== {1'b1, 12'hBF9, 53'd1 << 9, 1'b1, 12'hBDE, 53'd1 << 36}) begin
                failures++;
                $display("FAIL stall_hold[%0d] got s1 %b %h/%h s4 %b %h/%h",
                         k, busy1, exp1, mant1, busy4, exp4, mant4);
            end
        end
        en   = 1'b1;
        load = 1'b1;
        A    = 64'h3FF0000000000000;
        for (int e = 17; e <= 200; e++) begin
            step();
            if (e == 17) begin
                load = 1'b0;
                A    = JUNK;
            end
            if (ready1 && l1 < 0) l1 = e;
            if (ready4 && l4 < 0) l4 = e;
            if (l1 >= 0 && l4 >= 0) break;
        end
        checks++;
        if (l1 != 59 || l4 != 20) begin
            failures++;
            $display("FAIL stall_lat got s1=%0d s4=%0d want 59 20", l1, l4);
        end
        checks++;
        if ({exp1, mant1, fl1, exp4, mant4} !== {12'hBCE, ONE52, 5'b01000, 12'hBCE, ONE52}) begin
            failures++;
            $display("FAIL stall_res got s1 %h/%h/%b s4 %h/%h want BCE/%h/01000", exp1, mant1, fl1, exp4, mant4, ONE52);
        end
    endtask

    task automatic test_reset_mid();
        A    = 64'h1;
        load = 1'b1;
        step();
        load = 1'b0;
        for (int k = 0; k < 6; k++) step();
        rst = 1'b0;
        en  = 1'b0;
        step();
        checks++;
        if ({busy1, ready1, sign1, exp1, mant1, fl1, busy4, ready4, mant4} !== '0) begin
            failures++;
            $display("FAIL reset_mid got busy=%b ready=%b exp=%h mant=%h flags=%b s4 busy=%b mant=%h want 0",
                     busy1, ready1, exp1, mant1, fl1, busy4, mant4);
        end
        rst = 1'b1;
        en  = 1'b1;
        step();
        checks++;
        if ({busy1, ready1} !== 2'b00) begin
            failures++;
            $display("FAIL reset_mid_idle got busy=%b ready=%b want 0 0", busy1, ready1);
        end
    endtask

    task automatic test_back_to_back();
        int l1, l4, bc;
        run_op(64'h3FF0000000000000, l1, l4, bc);
        run_op(64'hC004000000000000, l1, l4, bc);
        checks++;
        if (l1 != 2 || l4 != 2) begin
            failures++;
            $display("FAIL b2b_lat got s1=%0d s4=%0d want 2", l1, l4);
        end
        checks++;
        if ({sign1, exp1, mant1, fl1} !== {1'b1, 12'h001, 53'h14000000000000, 5'b00000}) begin
            failures++;
            $display("FAIL b2b_res got sign=%b exp=%h mant=%h flags=%b", sign1, exp1, mant1, fl1);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_special();
        test_subnormal();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
